// File: rtl/kinase_seq_pkg.sv
// Shared types and constants for the kinase valve/pump sequencer.
// Valve polarity: 1 = pressurised (closed), 0 = vented (open).
package kinase_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        PUMP   = 2'd2,
        DWELL  = 2'd3
    } seq_state_t;

    // Static part of a command; cycle and dwell counts carry parameterised widths.
    typedef struct packed {
        logic [12:0] ctrl_a;
        logic [3:0]  ctrl_s;
        logic [1:0]  pump_sel;
        logic        pump_rev;
    } valve_cmd_t;

    localparam logic [12:0] SAFE_CTRL_A = 13'h1FFF;
    localparam logic [3:0]  SAFE_CTRL_S = 4'hF;
    localparam logic [2:0]  SAFE_PUMP_A = 3'b111;
    localparam logic [1:0]  SAFE_PUMP_B = 2'b11;

    localparam logic [2:0] PUMP_A_LAST = 3'd5;
    localparam logic [1:0] PUMP_B_LAST = 2'd3;

    // Entry [0] is the first forward phase.
    localparam logic [5:0][2:0] PUMP_A_TABLE = {3'b010, 3'b011, 3'b001, 3'b101, 3'b100, 3'b110};
    localparam logic [3:0][1:0] PUMP_B_TABLE = {2'b11, 2'b01, 2'b00, 2'b10};

    localparam valve_cmd_t SAFE_CMD = '{ctrl_a: SAFE_CTRL_A, ctrl_s: SAFE_CTRL_S,
                                        pump_sel: 2'b00, pump_rev: 1'b0};

    function automatic logic [2:0] pump_a_step(input logic [2:0] idx, input logic rev);
        if (rev)
            return (idx == 3'd0) ? PUMP_A_LAST : idx - 3'd1;
        return (idx == PUMP_A_LAST) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/kinase_valve_sequencer_pump.sv
// Peristaltic pump phase generator: walks the pump_a/pump_b phase tables for a
// requested number of full cycles and strobes finished on the last PUMP cycle.
module kinase_pump_phase_gen
    import kinase_seq_pkg::*;
#(
    parameter int PHASE_TICKS = 1000,
    parameter int CYCLE_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               start,
    input  logic [1:0]         sel,
    input  logic               rev,
    input  logic [CYCLE_W-1:0] cycles,
    output logic [2:0]         pump_a,
    output logic [1:0]         pump_b,
    output logic               finished
);

    localparam int TICK_W = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PHASE_TICKS - 1);

    logic               running_reg;
    logic [TICK_W-1:0]  tick_reg;
    logic [2:0]         phase_cnt_reg;
    logic [CYCLE_W-1:0] cycle_cnt_reg;
    logic [CYCLE_W-1:0] cycles_reg;
    logic [2:0]         idx_a_reg;
    logic [1:0]         idx_b_reg;
    logic [1:0]         sel_reg;
    logic               rev_reg;
    logic [2:0]         pump_a_reg;
    logic [1:0]         pump_b_reg;

    logic [2:0] phase_last;
    logic       tick_wrap;
    logic       cycle_end;
    logic       last_cycle;
    logic [2:0] idx_a_next;
    logic [1:0] idx_b_next;
    logic [2:0] idx_a_init;
    logic [1:0] idx_b_init;

    // A pump_b-only command is a 4-phase cycle; anything driving pump_a uses 6.
    always_comb begin
        phase_last = (sel_reg == 2'b10) ? {1'b0, PUMP_B_LAST} : PUMP_A_LAST;
        tick_wrap  = running_reg && (tick_reg == TICK_LAST);
        cycle_end  = tick_wrap && (phase_cnt_reg == phase_last);
        last_cycle = (cycle_cnt_reg == cycles_reg - CYCLE_W'(1));
        idx_a_next = pump_a_step(idx_a_reg, rev_reg);
        idx_b_next = rev_reg ? idx_b_reg - 2'd1 : idx_b_reg + 2'd1;
        idx_a_init = rev ? PUMP_A_LAST : 3'd0;
        idx_b_init = rev ? PUMP_B_LAST : 2'd0;
    end

    assign finished = cycle_end && last_cycle;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            running_reg   <= 1'b0;
            tick_reg      <= '0;
            phase_cnt_reg <= '0;
            cycle_cnt_reg <= '0;
            cycles_reg    <= '0;
            idx_a_reg     <= '0;
            idx_b_reg     <= '0;
            sel_reg       <= '0;
            rev_reg       <= 1'b0;
            pump_a_reg    <= SAFE_PUMP_A;
            pump_b_reg    <= SAFE_PUMP_B;
        end else if (start) begin
            running_reg   <= 1'b1;
            tick_reg      <= '0;
            phase_cnt_reg <= '0;
            cycle_cnt_reg <= '0;
            cycles_reg    <= cycles;
            sel_reg       <= sel;
            rev_reg       <= rev;
            idx_a_reg     <= idx_a_init;
            idx_b_reg     <= idx_b_init;
            pump_a_reg    <= sel[0] ? PUMP_A_TABLE[idx_a_init] : SAFE_PUMP_A;
            pump_b_reg    <= sel[1] ? PUMP_B_TABLE[idx_b_init] : SAFE_PUMP_B;
        end else if (finished) begin
            running_reg <= 1'b0;
            pump_a_reg  <= SAFE_PUMP_A;
            pump_b_reg  <= SAFE_PUMP_B;
        end else if (running_reg) begin
            if (tick_wrap) begin
                tick_reg   <= '0;
                idx_a_reg  <= idx_a_next;
                idx_b_reg  <= idx_b_next;
                pump_a_reg <= sel_reg[0] ? PUMP_A_TABLE[idx_a_next] : SAFE_PUMP_A;
                pump_b_reg <= sel_reg[1] ? PUMP_B_TABLE[idx_b_next] : SAFE_PUMP_B;
                if (cycle_end) begin
                    phase_cnt_reg <= '0;
                    cycle_cnt_reg <= cycle_cnt_reg + CYCLE_W'(1);
                end else begin
                    phase_cnt_reg <= phase_cnt_reg + 3'd1;
                end
            end else begin
                tick_reg <= tick_reg + TICK_W'(1);
            end
        end
    end

    assign pump_a = pump_a_reg;
    assign pump_b = pump_b_reg;

endmodule

// File: rtl/kinase_valve_sequencer.sv
// Valve/pump control sequencer for the kinase activity chip pads.
// Optional command FIFO enabled by defining KINASE_SEQ_FIFO_EN.
module kinase_valve_sequencer
    import kinase_seq_pkg::*;
#(
    parameter int PHASE_TICKS  = 1000,
    parameter int SETTLE_TICKS = 500,
    parameter int CYCLE_W      = 8,
    parameter int DWELL_W      = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [12:0]        cmd_ctrl_a,
    input  logic [3:0]         cmd_ctrl_s,
    input  logic [1:0]         cmd_pump_sel,
    input  logic               cmd_pump_rev,
    input  logic [CYCLE_W-1:0] cmd_cycles,
    input  logic [DWELL_W-1:0] cmd_dwell,
    input  logic               abort,
    output logic [12:0]        ctrl_a,
    output logic [3:0]         ctrl_s,
    output logic [2:0]         pump_a,
    output logic [1:0]         pump_b,
    output logic               busy,
    output logic               done
);

    localparam int SETTLE_W = $clog2(SETTLE_TICKS + 1);
    localparam int CNT_W    = (DWELL_W > SETTLE_W) ? DWELL_W : SETTLE_W;
    localparam int CMD_W    = $bits(valve_cmd_t) + CYCLE_W + DWELL_W;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        PHASE_TICKS < 1 || SETTLE_TICKS < 1) begin : g_param_check
        $error("kinase_valve_sequencer: illegal parameter value");
    end

    seq_state_t         state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    valve_cmd_t         cmd_reg;
    logic [CYCLE_W-1:0] cycles_reg;
    logic [DWELL_W-1:0] dwell_reg;
    logic               busy_reg;
    logic               done_reg, done_next;

    logic               load_cmd;
    logic               finish;
    logic               pump_start;
    logic               pump_finished;
    logic               pumps_needed;
    logic               cmd_avail;
    logic [CMD_W-1:0]   cmd_in_bus;
    logic [CMD_W-1:0]   cmd_head;
    valve_cmd_t         head_cfg;
    logic [CYCLE_W-1:0] head_cycles;
    logic [DWELL_W-1:0] head_dwell;

    assign cmd_in_bus = {cmd_ctrl_a, cmd_ctrl_s, cmd_pump_sel, cmd_pump_rev, cmd_cycles, cmd_dwell};
    assign {head_cfg, head_cycles, head_dwell} = cmd_head;

`ifdef KINASE_SEQ_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [CMD_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_reg, rd_ptr_reg;
    logic             fifo_full, fifo_empty, push;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                        (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign cmd_ready  = !fifo_full && !abort;
    assign push       = cmd_valid && cmd_ready;
    assign cmd_avail  = !fifo_empty;
    assign cmd_head   = fifo_mem[rd_ptr_reg[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= cmd_in_bus;
    end

    // Abort discards everything queued along with the running command.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
            if (load_cmd)
                rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
        end
    end
`else
    assign cmd_ready = (state_reg == IDLE) && !abort && !rst;
    assign cmd_avail = cmd_valid && cmd_ready;
    assign cmd_head  = cmd_in_bus;
`endif

    assign pumps_needed = (cmd_reg.pump_sel != 2'b00) && (cycles_reg != '0);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        load_cmd   = 1'b0;
        finish     = 1'b0;
        pump_start = 1'b0;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cmd_avail) begin
                    state_next = SETTLE;
                    cnt_next   = '0;
                    load_cmd   = 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_reg == SETTLE_LAST) begin
                    cnt_next = '0;
                    if (pumps_needed) begin
                        state_next = PUMP;
                        pump_start = 1'b1;
                    end else if (dwell_reg != '0) begin
                        state_next = DWELL;
                    end else begin
                        finish = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            PUMP: begin
                if (pump_finished) begin
                    cnt_next = '0;
                    if (dwell_reg != '0)
                        state_next = DWELL;
                    else
                        finish = 1'b1;
                end
            end
            DWELL: begin
                if (cnt_reg == CNT_W'(dwell_reg) - CNT_W'(1))
                    finish = 1'b1;
                else
                    cnt_next = cnt_reg + CNT_W'(1);
            end
            default: state_next = IDLE;
        endcase

        // A zero dwell folds the DWELL exit onto the SETTLE/PUMP exit edge.
        if (finish) begin
            done_next  = 1'b1;
            state_next = IDLE;
            cnt_next   = '0;
            if (cmd_avail) begin
                state_next = SETTLE;
                load_cmd   = 1'b1;
            end
        end

        if (abort) begin
            state_next = IDLE;
            cnt_next   = '0;
            load_cmd   = 1'b0;
            pump_start = 1'b0;
            done_next  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            cmd_reg    <= SAFE_CMD;
            cycles_reg <= '0;
            dwell_reg  <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            busy_reg  <= (state_next != IDLE);
            done_reg  <= done_next;
            if (load_cmd) begin
                cmd_reg    <= head_cfg;
                cycles_reg <= head_cycles;
                dwell_reg  <= head_dwell;
            end
        end
    end

    kinase_pump_phase_gen #(
        .PHASE_TICKS (PHASE_TICKS),
        .CYCLE_W     (CYCLE_W)
    ) u_pump (
        .clk      (clk),
        .rst      (rst),
        .clear    (abort),
        .start    (pump_start),
        .sel      (cmd_reg.pump_sel),
        .rev      (cmd_reg.pump_rev),
        .cycles   (cycles_reg),
        .pump_a   (pump_a),
        .pump_b   (pump_b),
        .finished (pump_finished)
    );

    assign ctrl_a = cmd_reg.ctrl_a;
    assign ctrl_s = cmd_reg.ctrl_s;
    assign busy   = busy_reg;
    assign done   = done_reg;

endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// Self-checking bench for kinase_valve_sequencer (default build, no command FIFO).
module tb_kinase_valve_sequencer;

    localparam int PT = 4;
    localparam int ST = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [12:0] cmd_ctrl_a = '0;
    logic [3:0]  cmd_ctrl_s = '0;
    logic [1:0]  cmd_pump_sel = '0;
    logic        cmd_pump_rev = 1'b0;
    logic [7:0]  cmd_cycles = '0;
    logic [15:0] cmd_dwell = '0;
    logic        abort = 1'b0;
    logic [12:0] ctrl_a;
    logic [3:0]  ctrl_s;
    logic [2:0]  pump_a;
    logic [1:0]  pump_b;
    logic        busy;
    logic        done;

    logic [2:0] pa_tab [6] = '{3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010};
    logic [1:0] pb_tab [4] = '{2'b10, 2'b00, 2'b01, 2'b11};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_done_q [$];

    kinase_valve_sequencer #(
        .PHASE_TICKS  (PT),
        .SETTLE_TICKS (ST),
        .CYCLE_W      (8),
        .DWELL_W      (16),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_ctrl_a   (cmd_ctrl_a),
        .cmd_ctrl_s   (cmd_ctrl_s),
        .cmd_pump_sel (cmd_pump_sel),
        .cmd_pump_rev (cmd_pump_rev),
        .cmd_cycles   (cmd_cycles),
        .cmd_dwell    (cmd_dwell),
        .abort        (abort),
        .ctrl_a       (ctrl_a),
        .ctrl_s       (ctrl_s),
        .pump_a       (pump_a),
        .pump_b       (pump_b),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expected cycle.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_done_q.size() == 0)
                check_value("unexpected_done", 32'(done), 32'd0);
            else
                check_value("done_cycle", 32'(cyc), 32'(exp_done_q.pop_front()));
        end
    end

    task automatic check_safe(input string tag);
        check_value({tag, "_ctrl_a"}, 32'(ctrl_a), 32'h1FFF);
        check_value({tag, "_ctrl_s"}, 32'(ctrl_s), 32'hF);
        check_value({tag, "_pumps"}, 32'({pump_a, pump_b}), 32'h1F);
        check_value({tag, "_busy"}, 32'(busy), 32'd0);
        check_value({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // Offer one command and follow it cycle by cycle; stop_at>0 kills it at that cycle.
    task automatic run_cmd(input logic [12:0] a, input logic [3:0] s, input logic [1:0] sel,
                           input logic rev, input int ncyc, input int dw,
                           input int stop_at, input bit use_rst);
        int phases, pump_len, lat, ph;
        logic [2:0] ea;
        logic [1:0] eb;
        phases   = (sel == 2'b10) ? 4 : 6;
        pump_len = (sel == 2'b00 || ncyc == 0) ? 0 : ncyc * phases * PT;
        lat      = 1 + ST + pump_len + dw;
        @(negedge clk);
        cmd_ctrl_a   = a;
        cmd_ctrl_s   = s;
        cmd_pump_sel = sel;
        cmd_pump_rev = rev;
        cmd_cycles   = 8'(ncyc);
        cmd_dwell    = 16'(dw);
        cmd_valid    = 1'b1;
        #1 check_value("ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        exp_done_q.push_back(cyc + lat - 1);
        $display("cmd ctrl_a=%h ctrl_s=%h sel=%b rev=%0d cycles=%0d dwell=%0d latency=%0d stop_at=%0d",
                 a, s, sel, rev, ncyc, dw, lat, stop_at);
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) @(negedge clk);
            ea = 3'b111;
            eb = 2'b11;
            if (k >= ST + 1 && k < ST + 1 + pump_len) begin
                ph = (k - ST - 1) / PT;
                if (sel[0]) ea = pa_tab[rev ? 5 - (ph % 6) : ph % 6];
                if (sel[1]) eb = pb_tab[rev ? 3 - (ph % 4) : ph % 4];
            end
            check_value("ctrl_a", 32'(ctrl_a), 32'(a));
            check_value("ctrl_s", 32'(ctrl_s), 32'(s));
            check_value("pumps", 32'({pump_a, pump_b}), 32'({ea, eb}));
            check_value("busy", 32'(busy), (k < lat) ? 32'd1 : 32'd0);
            if (k == stop_at) begin
                if (use_rst) rst = 1'b1;
                else abort = 1'b1;
                void'(exp_done_q.pop_back());
                #1 check_value("ready_in_stop", 32'(cmd_ready), 32'd0);
                @(posedge clk);
                #1;
                rst   = 1'b0;
                abort = 1'b0;
                @(negedge clk);
                check_safe(use_rst ? "after_rst" : "after_abort");
                check_value("ready_after_stop", 32'(cmd_ready), 32'd1);
                return;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_safe("reset");
        check_value("reset_ready", 32'(cmd_ready), 32'd1);

        run_cmd(13'h0AAA, 4'h5, 2'b01, 1'b0, 1, 3, 0, 1'b0);
        run_cmd(13'h1234, 4'h3, 2'b10, 1'b1, 2, 2, 0, 1'b0);
        run_cmd(13'h0F0F, 4'hA, 2'b00, 1'b0, 3, 0, 0, 1'b0);
        run_cmd(13'h0555, 4'h6, 2'b11, 1'b0, 1, 1, 0, 1'b0);
        run_cmd(13'h1111, 4'h1, 2'b11, 1'b1, 0, 2, 0, 1'b0);
        run_cmd(13'h0AAA, 4'h9, 2'b01, 1'b0, 2, 4, 10, 1'b0);
        run_cmd(13'h0333, 4'h2, 2'b10, 1'b0, 1, 0, 0, 1'b0);

        // abort together with an offered command: nothing is accepted
        @(negedge clk);
        cmd_valid = 1'b1;
        abort     = 1'b1;
        #1 check_value("ready_in_abort", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        abort     = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        check_safe("abort_idle");
        repeat (3) @(negedge clk);
        check_value("abort_idle_busy", 32'(busy), 32'd0);

        run_cmd(13'h0C3C, 4'h4, 2'b11, 1'b1, 1, 2, 2, 1'b1);
        run_cmd(13'h0001, 4'h8, 2'b11, 1'b1, 1, 2, 0, 1'b0);

        repeat (5) @(negedge clk);
        check_value("pending_done", 32'(exp_done_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
